// File: rtl/shadow_or_miss_arb.sv
// rtl/shadow_or_miss_arb.sv - two-port round-robin merge of shadow/miss results into one FIFO; optional grant counters under SHADOW_ARB_STATS_EN
module shadow_or_miss_arb #(
    parameter int  DEPTH = 4,
    parameter int  CNT_W = 16,
    parameter int  RAY_W = 8,
    localparam int DW    = RAY_W + 2,
    localparam int NW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ss_valid,
    input  logic [DW-1:0]    ss_data,
    output logic             ss_stall,
    input  logic             si_valid,
    input  logic [DW-1:0]    si_data,
    output logic             si_stall,
    output logic             som_valid,
    output logic [DW-1:0]    som_data,
    input  logic             som_stall,
    output logic [NW-1:0]    num_in_fifo,
    output logic [CNT_W-1:0] ss_grants,
    output logic [CNT_W-1:0] si_grants
);

    typedef struct packed {
        logic [RAY_W-1:0] ray_id;
        logic             is_shadow;
        logic             is_miss;
    } shadow_or_miss_t;

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);

    shadow_or_miss_t r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [NW-1:0]   r_count;
    logic            r_tok;

    logic            w_full;
    logic            w_empty;
    logic            w_ss_acc;
    logic            w_si_acc;
    logic            w_push;
    logic            w_pop;
    shadow_or_miss_t w_push_data;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // A port stalls when the FIFO is full or the other port holds priority and is
    // requesting; both stalls are forced low while reset is asserted.
    assign ss_stall = rst & (w_full | ( r_tok & si_valid));
    assign si_stall = rst & (w_full | (~r_tok & ss_valid));

    // The token makes these mutually exclusive: the non-priority port only
    // proceeds when the priority port is idle.
    assign w_ss_acc    = rst & ss_valid & ~ss_stall;
    assign w_si_acc    = rst & si_valid & ~si_stall;
    assign w_push      = w_ss_acc | w_si_acc;
    assign w_push_data = w_ss_acc ? ss_data : si_data;
    assign w_pop       = ~w_empty & ~som_stall;

    assign som_valid   = ~w_empty;
    assign som_data    = r_mem[r_rd_ptr];
    assign num_in_fifo = r_count;

    // Storage array needs no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // Pointers, occupancy and priority token; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_tok    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_tok    <= w_ss_acc;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + NW'(1);
                2'b01:   r_count <= r_count - NW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SHADOW_ARB_STATS_EN
    logic [CNT_W-1:0] r_ss_grants;
    logic [CNT_W-1:0] r_si_grants;

    // Saturating per-port accept counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ss_grants <= '0;
            r_si_grants <= '0;
        end else begin
            if (w_ss_acc && (r_ss_grants != {CNT_W{1'b1}})) begin
                r_ss_grants <= r_ss_grants + CNT_W'(1);
            end
            if (w_si_acc && (r_si_grants != {CNT_W{1'b1}})) begin
                r_si_grants <= r_si_grants + CNT_W'(1);
            end
        end
    end

    assign ss_grants = r_ss_grants;
    assign si_grants = r_si_grants;
`else
    assign ss_grants = '0;
    assign si_grants = '0;
`endif

endmodule

// File: tb/tb_shadow_or_miss_arb.sv
// tb/tb_shadow_or_miss_arb.sv - randomized self-checking bench for shadow_or_miss_arb
module tb_shadow_or_miss_arb;

    localparam int DEPTH = 4;
    localparam int NW    = 3;
    localparam int DW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          ss_valid, si_valid, som_stall;
    logic [DW-1:0] ss_data, si_data;
    logic          ss_stall, si_stall, som_valid;
    logic [DW-1:0] som_data;
    logic [NW-1:0] num_in_fifo;
    logic [15:0]   ss_grants, si_grants;

    logic          s_ss_stall, s_si_stall, s_som_valid;
    logic [DW-1:0] s_som_data;
    logic [NW-1:0] s_num;
    logic [1:0]    s_ss_grants, s_si_grants;

    int checks   = 0;
    int failures = 0;

    // reference model: queue contents, priority token, accept counts
    logic [DW-1:0] mq[$];
    logic [DW-1:0] dut_out[$];
    bit            mtok;
    int            m_ss_cnt, m_si_cnt;
    bit            m_ss_acc, m_si_acc;
    logic [15:0]   obs;

    shadow_or_miss_arb #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .ss_valid(ss_valid), .ss_data(ss_data), .ss_stall(ss_stall),
        .si_valid(si_valid), .si_data(si_data), .si_stall(si_stall),
        .som_valid(som_valid), .som_data(som_data), .som_stall(som_stall),
        .num_in_fifo(num_in_fifo), .ss_grants(ss_grants), .si_grants(si_grants)
    );

    shadow_or_miss_arb #(.DEPTH(DEPTH), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .ss_valid(ss_valid), .ss_data(ss_data), .ss_stall(s_ss_stall),
        .si_valid(si_valid), .si_data(si_data), .si_stall(s_si_stall),
        .som_valid(s_som_valid), .som_data(s_som_data), .som_stall(som_stall),
        .num_in_fifo(s_num), .ss_grants(s_ss_grants), .si_grants(s_si_grants)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] exp_vec();
        bit            full = (mq.size() == DEPTH);
        logic [DW-1:0] h    = (mq.size() != 0) ? mq[0] : '0;
        return {full || (mtok && si_valid), full || (!mtok && ss_valid),
                mq.size() != 0, NW'(mq.size()), h};
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        mq.delete();
        mtok     = 1'b0;
        m_ss_cnt = 0;
        m_si_cnt = 0;
    endtask

    // called at negedge; applies the rising-edge update to the model
    task automatic advance();
        bit            full = (mq.size() == DEPTH);
        bit            pop  = (mq.size() != 0) && !som_stall;
        logic [DW-1:0] sd   = ss_data;
        logic [DW-1:0] id   = si_data;
        m_ss_acc = ss_valid && !(full || (mtok && si_valid));
        m_si_acc = si_valid && !(full || (!mtok && ss_valid));
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (m_ss_acc) begin mq.push_back(sd); mtok = 1'b1; m_ss_cnt++; end
        else if (m_si_acc) begin mq.push_back(id); mtok = 1'b0; m_si_cnt++; end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; ss_valid = 1'b0; si_valid = 1'b0; som_stall = 1'b0;
        model_reset();
        dut_out.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; ss_valid = 1'b1; si_valid = 1'b1; som_stall = 1'b0;
        ss_data = 10'h3ff; si_data = 10'h155;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({ss_stall, si_stall, som_valid} !== 3'b000) begin
                failures++;
                $display("FAIL reset_flags got=%b want=000", {ss_stall, si_stall, som_valid});
            end
            checks++;
            if (num_in_fifo !== '0) begin
                failures++;
                $display("FAIL reset_count got=%0d want=0", num_in_fifo);
            end
            checks++;
            if ({ss_grants, si_grants, s_ss_grants, s_si_grants} !== 36'h0) begin
                failures++;
                $display("FAIL reset_grants got=%h want=0", {ss_grants, si_grants, s_ss_grants, s_si_grants});
            end
        end
        @(posedge clk);
        #1 rst = 1'b1; ss_valid = 1'b0; si_valid = 1'b0;
    endtask

    task automatic test_ss_only();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            ss_valid = (c < 3);
            si_valid = 1'b0;
            ss_data  = {8'(c + 1), 2'($urandom)};
            @(negedge clk);
            obs = {ss_stall, si_stall, som_valid, num_in_fifo, som_valid ? som_data : 10'h0};
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL ss_only_cycle%0d got=%h want=%h", c, obs, exp_vec());
            end
            if (c == 1) begin
                checks++;
                if (!(som_valid && som_data[9:2] == 8'd1)) begin
                    failures++;
                    $display("FAIL ss_only_latency got=%b/%0d want=1/1", som_valid, som_data[9:2]);
                end
            end
            if (som_valid && !som_stall) dut_out.push_back(som_data);
            advance();
        end
        checks++;
        if (dut_out.size() != 3) begin
            failures++;
            $display("FAIL ss_only_count got=%0d want=3", dut_out.size());
        end
        for (int i = 0; i < dut_out.size() && i < 3; i++) begin
            checks++;
            if (dut_out[i][9:2] !== 8'(i + 1)) begin
                failures++;
                $display("FAIL ss_only_order idx%0d got=%0d want=%0d", i, dut_out[i][9:2], i + 1);
            end
        end
    endtask

    task automatic test_alternate();
        int ss_n = 0;
        int si_n = 0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            ss_valid = (c < 10);
            si_valid = (c < 10);
            ss_data  = {8'(10 + ss_n), 2'b01};
            si_data  = {8'(20 + si_n), 2'b10};
            @(negedge clk);
            obs = {ss_stall, si_stall, som_valid, num_in_fifo, som_valid ? som_data : 10'h0};
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL alternate_cycle%0d got=%h want=%h", c, obs, exp_vec());
            end
            if (som_valid && !som_stall) dut_out.push_back(som_data);
            advance();
            if (m_ss_acc) ss_n++;
            if (m_si_acc) si_n++;
        end
        checks++;
        if (dut_out.size() < 8) begin
            failures++;
            $display("FAIL alternate_count got=%0d want>=8", dut_out.size());
        end
        for (int i = 0; i < 8 && i < dut_out.size(); i++) begin
            checks++;
            if (dut_out[i][9:2] !== 8'(((i % 2) == 0 ? 10 : 20) + i / 2)) begin
                failures++;
                $display("FAIL alternate_order idx%0d got=%0d want=%0d", i, dut_out[i][9:2],
                         ((i % 2) == 0 ? 10 : 20) + i / 2);
            end
        end
    endtask

    task automatic test_full();
        int ss_n = 0;
        int si_n = 0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            som_stall = (c < 8);
            ss_valid  = 1'b1;
            si_valid  = 1'b1;
            ss_data   = {8'(30 + ss_n), 2'($urandom)};
            si_data   = {8'(40 + si_n), 2'($urandom)};
            @(negedge clk);
            obs = {ss_stall, si_stall, som_valid, num_in_fifo, som_valid ? som_data : 10'h0};
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL full_cycle%0d got=%h want=%h", c, obs, exp_vec());
            end
            if (c == 8) begin
                checks++;
                if ({num_in_fifo, ss_stall, si_stall} !== {3'd4, 2'b11}) begin
                    failures++;
                    $display("FAIL full_pop_same_cycle got=%0d/%b want=4/11", num_in_fifo, {ss_stall, si_stall});
                end
            end
            if (som_valid && !som_stall) dut_out.push_back(som_data);
            advance();
            if (m_ss_acc) ss_n++;
            if (m_si_acc) si_n++;
        end
        for (int i = 0; i < 4 && i < dut_out.size(); i++) begin
            checks++;
            if (dut_out[i][9:2] !== 8'(((i % 2) == 0 ? 30 : 40) + i / 2)) begin
                failures++;
                $display("FAIL full_drain idx%0d got=%0d want=%0d", i, dut_out[i][9:2],
                         ((i % 2) == 0 ? 30 : 40) + i / 2);
            end
        end
        checks++;
        if (dut_out.size() <= 4) begin
            failures++;
            $display("FAIL full_resume got=%0d outputs want>4", dut_out.size());
        end
    endtask

    task automatic test_wrap();
        int            sent = 0;
        int            cyc  = 0;
        bit            have = 1'b0;
        bit            port = 1'b0;
        logic [DW-1:0] item = '0;
        do_reset();
        while ((sent < 3 * DEPTH + 1 || mq.size() != 0) && cyc < 600) begin
            if (!have && sent < 3 * DEPTH + 1 && $urandom_range(3) != 0) begin
                have = 1'b1;
                port = 1'($urandom_range(1));
                item = {8'(100 + sent), 2'($urandom)};
            end
            ss_valid  = have && !port;
            si_valid  = have && port;
            ss_data   = item;
            si_data   = item;
            som_stall = 1'($urandom_range(1));
            @(negedge clk);
            obs = {ss_stall, si_stall, som_valid, num_in_fifo, som_valid ? som_data : 10'h0};
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL wrap_cycle%0d got=%h want=%h", cyc, obs, exp_vec());
            end
            if (som_valid && !som_stall) dut_out.push_back(som_data);
            advance();
            if (m_ss_acc || m_si_acc) begin sent++; have = 1'b0; end
            cyc++;
        end
        ss_valid = 1'b0; si_valid = 1'b0; som_stall = 1'b0;
        checks++;
        if (cyc >= 600) begin
            failures++;
            $display("FAIL wrap_timeout got=%0d sent want=%0d", sent, 3 * DEPTH + 1);
        end
        checks++;
        if (dut_out.size() != 3 * DEPTH + 1) begin
            failures++;
            $display("FAIL wrap_count got=%0d want=%0d", dut_out.size(), 3 * DEPTH + 1);
        end
        for (int i = 0; i < dut_out.size(); i++) begin
            checks++;
            if (dut_out[i][9:2] !== 8'(100 + i)) begin
                failures++;
                $display("FAIL wrap_order idx%0d got=%0d want=%0d", i, dut_out[i][9:2], 100 + i);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            ss_valid  = 1'($urandom_range(1));
            si_valid  = 1'($urandom_range(1));
            ss_data   = 10'($urandom);
            si_data   = 10'($urandom);
            som_stall = ($urandom_range(2) == 0);
            @(negedge clk);
            obs = {ss_stall, si_stall, som_valid, num_in_fifo, som_valid ? som_data : 10'h0};
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL random_cycle%0d got=%h want=%h", c, obs, exp_vec());
            end
            advance();
        end
        @(negedge clk);
        checks++;
`ifdef SHADOW_ARB_STATS_EN
        if ({ss_grants, si_grants, s_ss_grants, s_si_grants} !==
            {16'(m_ss_cnt), 16'(m_si_cnt), 2'(sat(m_ss_cnt, 3)), 2'(sat(m_si_cnt, 3))}) begin
`else
        if ({ss_grants, si_grants, s_ss_grants, s_si_grants} !== 36'h0) begin
`endif
            failures++;
            $display("FAIL random_grants got=%0d/%0d/%0d/%0d model=%0d/%0d", ss_grants, si_grants,
                     s_ss_grants, s_si_grants, m_ss_cnt, m_si_cnt);
        end
        ss_valid = 1'b0; si_valid = 1'b0; som_stall = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_grants();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            ss_valid = (c < 5);
            si_valid = (c >= 5);
            ss_data  = {8'(50 + c), 2'b00};
            si_data  = {8'(60 + c), 2'b11};
            @(negedge clk);
            obs = {ss_stall, si_stall, som_valid, num_in_fifo, som_valid ? som_data : 10'h0};
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL grants_cycle%0d got=%h want=%h", c, obs, exp_vec());
            end
            advance();
        end
        ss_valid = 1'b0; si_valid = 1'b0;
        @(negedge clk);
        checks++;
`ifdef SHADOW_ARB_STATS_EN
        if ({ss_grants, si_grants} !== {16'd5, 16'd7}) begin
            failures++;
            $display("FAIL grants_5_7 got=%0d/%0d want=5/7", ss_grants, si_grants);
        end
        checks++;
        if ({s_ss_grants, s_si_grants} !== {2'd3, 2'd3}) begin
            failures++;
            $display("FAIL grants_saturate got=%0d/%0d want=3/3", s_ss_grants, s_si_grants);
        end
`else
        if ({ss_grants, si_grants, s_ss_grants, s_si_grants} !== 36'h0) begin
            failures++;
            $display("FAIL grants_disabled got=%h want=0", {ss_grants, si_grants, s_ss_grants, s_si_grants});
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset();
        do_reset();
        som_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            ss_valid = 1'b1;
            ss_data  = {8'(70 + c), 2'b01};
            @(negedge clk);
            advance();
        end
        ss_valid = 1'b0;
        checks++;
        if (num_in_fifo !== 3'd3) begin
            failures++;
            $display("FAIL midreset_fill got=%0d want=3", num_in_fifo);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({som_valid, num_in_fifo} !== 4'b0000) begin
            failures++;
            $display("FAIL midreset_async got=%b/%0d want=0/0", som_valid, num_in_fifo);
        end
        model_reset();
        dut_out.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        som_stall = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            obs = {ss_stall, si_stall, som_valid, num_in_fifo, som_valid ? som_data : 10'h0};
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL midreset_after%0d got=%h want=%h", c, obs, exp_vec());
            end
            advance();
        end
    endtask

    initial begin
        ss_data = '0;
        si_data = '0;
        test_reset();
        test_ss_only();
        test_alternate();
        test_full();
        test_wrap();
        test_random();
        test_grants();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shadow_or_miss_arb.md
SHADOW_OR_MISS_ARB -- requirements
Module: shadow_or_miss_arb

Interface
REQ-001 Parameter DEPTH, default 4, meaning output FIFO entries (power of two, 2..16).
REQ-002 Parameter CNT_W, default 16, meaning width of each grant counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 ss_valid  input  1  send_shadow hit-result (shadow_or_miss) valid.
REQ-006 ss_data  input  $bits(shadow_or_miss_t)  send_shadow result {rayID, is_shadow, is_miss}.
REQ-007 ss_stall  output  1  backpressure to send_shadow.
REQ-008 si_valid  input  1  shadow-intersection result valid.
REQ-009 si_data  input  $bits(shadow_or_miss_t)  shadow-intersection result.
REQ-010 si_stall  output  1  backpressure to shadow intersection.
REQ-011 som_valid  output  1  merged stream to color accumulation valid.
REQ-012 som_data  output  $bits(shadow_or_miss_t)  merged stream data.
REQ-013 som_stall  input  1  downstream backpressure.
REQ-014 num_in_fifo  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 ss_grants, si_grants  output  CNT_W each  accepted-transfer counters (see Configuration).

Function
REQ-016 Port X accepted in a cycle iff X_valid && ~X_stall; at most one port accepted per cycle.
REQ-017 Priority token tok (1 bit, 0 = ss, 1 = si); X_stall = full || (tok != X && other_valid); X_stall never depends on X's own valid.
REQ-018 After an accept from port X, tok points to the other port next cycle; with no accept, tok holds.
REQ-019 Accepted data written into FIFO tail at the accepting edge, bit-exact; no field is modified.
REQ-020 som_valid = ~empty; som_data = FIFO head; head popped when som_valid && ~som_stall.
REQ-021 Latency: input accepted at edge N is visible on som_data after edge N when FIFO was empty (som_valid high in cycle N+1).
REQ-022 Order preserved: output order equals acceptance order across both ports.
REQ-023 full = (num_in_fifo == DEPTH); when full both stalls asserted even if a pop occurs in the same cycle (no write-through on full).
REQ-024 Simultaneous push and pop with FIFO non-full and non-empty: occupancy unchanged.
REQ-025 Push into empty FIFO with som_stall high: entry retained, som_valid stays high until popped.
REQ-026 Read/write pointers wrap modulo DEPTH without loss or duplication.
REQ-027 som_data held stable while som_valid && som_stall.

Reset
REQ-028 While rst low: FIFO empty, num_in_fifo = 0, som_valid = 0, tok = 0, grant counters = 0, both stalls = 0.
REQ-029 Reset asserted mid-operation discards all FIFO contents immediately (asynchronously); no entry is emitted after release.
REQ-030 First accept possible at the first rising edge after rst rises.

Configuration
REQ-031 Macro SHADOW_ARB_STATS_EN: when defined, ss_grants/si_grants increment by 1 per accept on their port, saturating at 2^CNT_W-1.
REQ-032 Without SHADOW_ARB_STATS_EN, ss_grants and si_grants are constant 0 and no counter registers exist; all other behaviour identical.

Verification
REQ-033 Reset, then ss_valid only with rayIDs 1,2,3, som_stall=0 -> som_data rayIDs 1,2,3 on consecutive cycles, first one cycle after first accept.
REQ-034 Both ports valid continuously (ss rayIDs 10.., si rayIDs 20..), som_stall=0 -> output alternates 10,20,11,21,...; ss accepted first after reset.
REQ-035 som_stall=1, both valid -> exactly DEPTH=4 accepts, num_in_fifo=4, both stalls 1; release som_stall -> 4 entries drain in acceptance order, then accepts resume.
REQ-036 Drive 3*DEPTH+1 single-port transfers with random som_stall -> every rayID appears exactly once, in order (pointer wrap check).
REQ-037 Assert rst low with 3 entries queued -> som_valid=0 and num_in_fifo=0 immediately; after release no stale rayID appears.
REQ-038 With SHADOW_ARB_STATS_EN, 5 ss and 7 si accepts -> ss_grants=5, si_grants=7; CNT_W=2 with 5 accepts -> counter saturates at 3; without macro both read 0.
